// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: one on-screen sprite. Holds the sprite position and a colour
// ROM, and turns LOAD / MOVE / CLEAR / REDRAW commands into erase/draw pixel
// streams for a downstream plot writer. The writer can stall the stream with pix_ready.
//
// The ROM image is the ROM_IMAGE parameter: SPR_W*SPR_H words of COL_W bits,
// raster order, word i at bits [i*COL_W +: COL_W].
//
// Optional feature macro: SPRITE_TRANSPARENCY_EN. When it is defined, DRAW skips
// ROM words equal to 0, so those pixels are not emitted. ERASE is unaffected.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_op                 00 LOAD, 01 MOVE, 10 CLEAR, 11 REDRAW
//   cmd_dx/cmd_dy          signed deltas for MOVE
//   load_x/load_y          absolute position for LOAD
//   pix_valid/pix_ready    pixel handshake
//   pix_x/pix_y/pix_colour pixel word
//   done                   one-cycle pulse when a command finishes
//   pos_x/pos_y            current sprite position
module sprite_draw_engine #(
    parameter int unsigned SPR_W  = 16,
    parameter int unsigned SPR_H  = 4,
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 7,
    parameter int unsigned COL_W  = 12,
    parameter int unsigned INIT_X = 180,
    parameter int unsigned INIT_Y = 100,
    parameter logic [SPR_W*SPR_H*COL_W-1:0] ROM_IMAGE = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [X_W-1:0]   cmd_dx,
    input  logic [Y_W-1:0]   cmd_dy,
    input  logic [X_W-1:0]   load_x,
    input  logic [Y_W-1:0]   load_y,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic [COL_W-1:0] pix_colour,
    output logic             done,
    output logic [X_W-1:0]   pos_x,
    output logic [Y_W-1:0]   pos_y
);

    localparam int unsigned N        = SPR_W * SPR_H;
    localparam int unsigned PTR_W    = $clog2(N);
    localparam int unsigned COL_BITS = $clog2(SPR_W);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_MOVE   = 2'b01;
    localparam logic [1:0] OP_REDRAW = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [X_W-1:0]   pos_x_nxt;
    logic [Y_W-1:0]   pos_y_nxt;
    logic [1:0]       op_q;
    logic [X_W-1:0]   dx_q, lx_q;
    logic [Y_W-1:0]   dy_q, ly_q;
    logic             accept;
    logic             advance;
    logic             emit;
    logic [X_W-1:0]   pix_x_nxt;
    logic [Y_W-1:0]   pix_y_nxt;
    logic [COL_W-1:0] pix_colour_nxt;

    // Unpack the ROM image into addressable words
    logic [COL_W-1:0] rom [N];
    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom[g] = ROM_IMAGE[g*COL_W +: COL_W];
    end

    // Next-state, pointer walk, position update and next pixel word
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        pos_x_nxt      = pos_x;
        pos_y_nxt      = pos_y;
        accept         = 1'b0;
        emit           = 1'b0;
        pix_colour_nxt = '0;
        // A slot that holds no valid pixel (a transparent skip) is consumed unconditionally
        advance        = pix_ready || !pix_valid;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    case (cmd_op)
                        OP_LOAD:   state_nxt = S_DONE;
                        OP_REDRAW: state_nxt = S_DRAW;
                        default:   state_nxt = S_ERASE;
                    endcase
                end
            end
            S_ERASE: begin
                if (advance) begin
                    if (ptr == LAST) begin
                        ptr_nxt = '0;
                        if (op_q == OP_MOVE) begin
                            state_nxt = S_DRAW;
                            pos_x_nxt = pos_x + dx_q;
                            pos_y_nxt = pos_y + dy_q;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end else begin
                        ptr_nxt = ptr + PTR_W'(1);
                    end
                end
            end
            S_DRAW: begin
                if (advance) begin
                    if (ptr == LAST) begin
                        ptr_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        ptr_nxt = ptr + PTR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                if (op_q == OP_LOAD) begin
                    pos_x_nxt = lx_q;
                    pos_y_nxt = ly_q;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Pixel word for the slot the pointer moves to; ERASE uses the old position
        if (state_nxt == S_ERASE) begin
            emit = 1'b1;
        end else if (state_nxt == S_DRAW) begin
            pix_colour_nxt = rom[ptr_nxt];
`ifdef SPRITE_TRANSPARENCY_EN
            emit = |rom[ptr_nxt];
`else
            emit = 1'b1;
`endif
        end
        pix_x_nxt = pos_x_nxt + X_W'(ptr_nxt[COL_BITS-1:0]);
        pix_y_nxt = pos_y_nxt + Y_W'(ptr_nxt >> COL_BITS);
    end

    // State, position, operand latches and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ptr        <= '0;
            pos_x      <= X_W'(INIT_X);
            pos_y      <= Y_W'(INIT_Y);
            op_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            pos_x     <= pos_x_nxt;
            pos_y     <= pos_y_nxt;
            pix_valid <= emit;
            done      <= (state == S_DONE);
            cmd_ready <= (state_nxt == S_IDLE);
            if (accept) begin
                op_q <= cmd_op;
                dx_q <= cmd_dx;
                dy_q <= cmd_dy;
                lx_q <= load_x;
                ly_q <= load_y;
            end
            // Pixel word only changes when a new one is presented
            if (emit) begin
                pix_x      <= pix_x_nxt;
                pix_y      <= pix_y_nxt;
                pix_colour <= pix_colour_nxt;
            end
        end
    end

endmodule
